// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared add/correct stage, sequenced LSD first,
// with a start/busy/done handshake and a sticky invalid-digit flag.
module bcd_serial_add_ctrl #(
  parameter int unsigned NDIG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [4*NDIG-1:0] sum,
  output logic            cout,
  output logic            err
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;

  logic [4:0]      w_t;
  logic [3:0]      w_digit;
  logic            w_carry;
  logic [W-1:0]    w_res_shift;
  logic            w_bad;

  // Single-digit BCD add with +6 correction on the low operand digits.
  always_comb begin
    w_t = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_carry);
    if (w_t > 5'd9) begin
      w_digit = 4'(w_t + 5'd6);
      w_carry = 1'b1;
    end else begin
      w_digit = w_t[3:0];
      w_carry = 1'b0;
    end
  end

  // New digit enters the result from the top so digit 0 lands at [3:0] after NDIG steps.
  assign w_res_shift = W'({w_digit, r_res} >> 4);

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            err     <= w_bad;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // Abort wins over the final-digit transition and leaves results untouched.
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_res   <= w_res_shift;
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CW'(NDIG - 1)) begin
              sum     <= w_res_shift;
              cout    <= w_carry;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized scoreboard bench for bcd_serial_add_ctrl against a decimal-arithmetic model.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 4 * NDIG;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic prev_done = 1'b0;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Valid operands: decimal arithmetic. Invalid digits: the per-digit +6 rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t         r;
    logic [W-1:0] s;
    logic [3:0]   dx, dy;
    longint       va, vb, tot;
    int           t, cy;
    bit           ok;
    ok = 1; va = 0; vb = 0; s = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      dx = x[4*i +: 4];
      dy = y[4*i +: 4];
      if (dx > 4'd9 || dy > 4'd9) ok = 0;
    end
    if (ok) begin
      for (int i = int'(NDIG) - 1; i >= 0; i--) begin
        dx = x[4*i +: 4];
        dy = y[4*i +: 4];
        va = va * 10 + longint'(dx);
        vb = vb * 10 + longint'(dy);
      end
      tot = va + vb + longint'(c);
      for (int i = 0; i < int'(NDIG); i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
      r.c = (tot != 0);
    end else begin
      cy = int'(c);
      for (int i = 0; i < int'(NDIG); i++) begin
        t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cy;
        if (t > 9) begin s[4*i +: 4] = 4'((t + 6) % 16); cy = 1; end
        else       begin s[4*i +: 4] = 4'(t);            cy = 0; end
      end
      r.c = (cy != 0);
    end
    r.s = s;
    r.e = !ok;
    return r;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("err_at_done", 32'(err), 32'(e.e));
      end
    end
    prev_done = done;
  end

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input bit extra_start);
    exp_t         e;
    logic [W-1:0] old_sum;
    logic         old_cout;
    int           nbusy;
    bit           hold_ok, seen;
    e = model(xa, xb, xc);
    q.push_back(e);
    old_sum = sum;
    old_cout = cout;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_capture", 32'(err), 32'(e.e));
    start = extra_start;
    nbusy = 0; hold_ok = 1; seen = 0;
    for (int k = 0; k < int'(4 * NDIG + 4) && !seen; k++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        if (sum !== old_sum || cout !== old_cout) hold_ok = 0;
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * NDIG + 4);
    end
    chk("busy_cycles", 32'(nbusy), 32'(NDIG));
    chk("sum_hold_while_busy", 32'(hold_ok), 32'd1);
    if (extra_start) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_ignored_in_done", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      chk("idle_after_extra_start", 32'(busy), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_abort(input logic [W-1:0] xa, input logic [W-1:0] xb);
    logic [W-1:0] old_sum;
    logic         old_cout, old_err;
    bit           quiet;
    old_sum = sum; old_cout = cout; old_err = err;
    @(negedge clk);
    a = xa; b = xb; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy_low", 32'(busy), 32'd0);
    quiet = 1;
    repeat (NDIG + 2) begin
      @(negedge clk);
      if (busy || done) quiet = 0;
    end
    chk("abort_no_done", 32'(quiet), 32'd1);
    chk("abort_sum_kept", 32'(sum), 32'(old_sum));
    chk("abort_cout_kept", 32'(cout), 32'(old_cout));
    chk("abort_err_kept", 32'(err), 32'(old_err));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < int'(NDIG); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h9999, 16'h0000, 1'b1, 0);
    run_op(16'h0999, 16'h0000, 1'b1, 0);
    run_op(16'h00A3, 16'h0001, 1'b0, 0);
    run_op(16'h4321, 16'h1111, 1'b0, 0);
    run_op(16'h2468, 16'h1357, 1'b1, 1);
    run_abort(16'h5555, 16'h5555);
    run_op(16'h0500, 16'h0500, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end

    // Reset mid-operation after an invalid-digit capture so err is high beforehand.
    run_op(16'h8765, 16'h4321, 1'b0, 0);
    @(negedge clk);
    a = 16'h00F1; b = 16'h0002; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_sum", 32'(sum), 32'd0);
    chk("rst_mid_cout", 32'(cout), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
